ntt_ctrl: RTL

Sequencer that runs a full in-place forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT over an N-coefficient polynomial mod q = 8380417 by driving the combinational `butterfly` block. It generates coefficient-pair and twiddle addresses and reads operands from a dual-port coefficient RAM and a twiddle ROM. It presents the operands to the butterfly and writes the 23-bit results back to the same addresses. It sits between the polynomial memory and the butterfly datapath and is the operand producer and result consumer of the butterfly interface.

---
 rtl/ntt_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ntt_ctrl.sv
// Address sequencer for an in-place forward (CT) or inverse (GS) NTT over N coefficients.
// Three-stage pipeline: issue addresses, register RAM/ROM data as operands, write back butterfly results.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one coefficient pair issued per cycle, N/2 cycles per layer
// DRAIN | two cycles that let the layer's last writes land
// DONE  | one-cycle completion pulse
module ntt_ctrl #(
    parameter int N    = 256,
    parameter int LOGN = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [LOGN-1:0] rd_addr_a_o,
    output logic [LOGN-1:0] rd_addr_b_o,
    input  logic [22:0]     rd_data_a_i,
    input  logic [22:0]     rd_data_b_i,
    output logic [LOGN-1:0] tw_addr_o,
    input  logic [22:0]     tw_data_i,
    output logic [23:0]     a_o,
    output logic [23:0]     b_o,
    output logic [22:0]     twiddle_o,
    output logic            sel_red_o,
    output logic            sel_butterfly_o,
    input  logic [22:0]     bf_a_i,
    input  logic [22:0]     bf_b_i,
    output logic            we_o,
    output logic [LOGN-1:0] wr_addr_a_o,
    output logic [LOGN-1:0] wr_addr_b_o,
    output logic [22:0]     wr_data_a_o,
    output logic [22:0]     wr_data_b_o
);

    localparam int LW = $clog2(LOGN);
    localparam int PW = LOGN - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW-1:0]   PAIR_LAST    = PW'(N / 2 - 1);
    localparam logic [LW-1:0]   LAYER_LAST   = LW'(LOGN - 1);
    localparam logic [LOGN-1:0] TW_FWD_FIRST = LOGN'(1);
    localparam logic [LOGN-1:0] TW_INV_FIRST = LOGN'(N - 1);

    logic [1:0]      state;
    logic            mode;
    logic [LW-1:0]   layer;
    logic [PW-1:0]   pair;
    logic [PW-1:0]   mask;
    logic [LOGN-1:0] tw;
    logic            drain_cnt;

    logic            run;
    logic [PW-1:0]   offs;
    logic [PW-1:0]   hi;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] len;
    logic            block_end;

    logic            s1_valid;
    logic            s1_last;
    logic [LOGN-1:0] s1_addr_a;
    logic [LOGN-1:0] s1_addr_b;

    // mask = len-1; the pair index is split around bit log2(len) to form j,
    // and the inserted bit (always 0 in j) becomes the partner j+len.
    assign run       = (state == S_RUN);
    assign offs      = pair & mask;
    assign hi        = pair & ~mask;
    assign addr_a    = {hi, 1'b0} | {1'b0, offs};
    assign len       = {1'b0, mask} + 1'b1;
    assign block_end = (offs == mask);

    assign rd_addr_a_o     = run ? addr_a : '0;
    assign rd_addr_b_o     = run ? (addr_a | len) : '0;
    assign tw_addr_o       = run ? tw : '0;
    assign busy_o          = (state != S_IDLE);
    assign done_o          = (state == S_DONE);
    assign sel_butterfly_o = mode;
    assign wr_data_a_o     = we_o ? bf_a_i : '0;
    assign wr_data_b_o     = we_o ? bf_b_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            mode      <= 1'b0;
            layer     <= '0;
            pair      <= '0;
            mask      <= '0;
            tw        <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state <= S_RUN;
                        mode  <= mode_i;
                        layer <= '0;
                        pair  <= '0;
                        mask  <= mode_i ? '0 : '1;
                        tw    <= mode_i ? TW_INV_FIRST : TW_FWD_FIRST;
                    end
                end
                S_RUN: begin
                    pair <= pair + 1'b1;
                    if (block_end)
                        tw <= mode ? (tw - 1'b1) : (tw + 1'b1);
                    if (pair == PAIR_LAST) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 1'b0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (layer == LAYER_LAST) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                        layer <= layer + 1'b1;
                        mask  <= mode ? ((mask << 1) | PW'(1)) : (mask >> 1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand and write-back stages; addresses ride along with the RAM latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr_a   <= '0;
            s1_addr_b   <= '0;
            we_o        <= 1'b0;
            wr_addr_a_o <= '0;
            wr_addr_b_o <= '0;
            a_o         <= '0;
            b_o         <= '0;
            twiddle_o   <= '0;
            sel_red_o   <= 1'b0;
        end else begin
            s1_valid    <= run;
            s1_last     <= run && (layer == LAYER_LAST);
            s1_addr_a   <= rd_addr_a_o;
            s1_addr_b   <= rd_addr_b_o;
            we_o        <= s1_valid;
            wr_addr_a_o <= s1_addr_a;
            wr_addr_b_o <= s1_addr_b;
            a_o         <= s1_valid ? {1'b0, rd_data_a_i} : '0;
            b_o         <= s1_valid ? {1'b0, rd_data_b_i} : '0;
            twiddle_o   <= s1_valid ? tw_data_i : '0;
            sel_red_o   <= s1_last;
        end
    end

endmodule
